// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO default constants and pointer/count width helpers
package fifo_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 16;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so the occupancy can represent DEPTH itself.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/param_fifo_if.sv
// rtl/param_fifo_if.sv - FIFO write/read/status bundle with master and slave views
interface param_fifo_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
);
  localparam int CW = count_width(DEPTH);

  logic              en_write;
  logic [DATA_W-1:0] data_in;
  logic              en_read;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;

  modport master (
    output en_write, data_in, en_read,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  en_write, data_in, en_read,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DATA_W x DEPTH storage, one write port, one registered read port
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  localparam int PW    = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [PW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [PW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is never cleared; only the read register returns to zero.
  always_ff @(posedge clk) begin
    if (!reset && we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/param_fifo.sv
// rtl/param_fifo.sv - synchronous FIFO control, count and flags; FIFO_FWFT_EN selects first-word-fall-through
module param_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input logic         clk,
  input logic         reset,
  param_fifo_if.slave bus
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = count_width(DEPTH);

  if (!is_pow2(DEPTH) || DEPTH < 4 || AE_LEVEL >= AF_LEVEL) begin : g_bad_cfg
    $error("param_fifo: DEPTH must be a power of two >= 4 and AE_LEVEL < AF_LEVEL");
  end

  logic [PW-1:0]     wptr, rptr, rptr_next, raddr;
  logic [CW-1:0]     cnt, cnt_next;
  logic              rd_acc, wr_acc, re;
  logic [DATA_W-1:0] mem_rdata;

  // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
  always_comb begin
    rd_acc    = bus.en_read && !bus.empty;
    wr_acc    = bus.en_write && (!bus.full || rd_acc);
    rptr_next = rptr + PW'(rd_acc);
    cnt_next  = cnt;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_next = cnt + CW'(1);
      2'b01:   cnt_next = cnt - CW'(1);
      default: cnt_next = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr             <= '0;
      rptr             <= '0;
      cnt              <= '0;
      bus.full         <= 1'b0;
      bus.empty        <= 1'b1;
      bus.almost_full  <= 1'b0;
      bus.almost_empty <= 1'b1;
      bus.overflow     <= 1'b0;
      bus.underflow    <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + PW'(1);
      rptr             <= rptr_next;
      cnt              <= cnt_next;
      bus.full         <= (cnt_next == CW'(DEPTH));
      bus.empty        <= (cnt_next == '0);
      bus.almost_full  <= (cnt_next >= CW'(AF_LEVEL));
      bus.almost_empty <= (cnt_next <= CW'(AE_LEVEL));
      bus.overflow     <= bus.en_write && !wr_acc;
      bus.underflow    <= bus.en_read && !rd_acc;
    end
  end

  assign bus.count = cnt;

  fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (wr_acc),
    .waddr (wptr),
    .wdata (bus.data_in),
    .re    (re),
    .raddr (raddr),
    .rdata (mem_rdata)
  );

`ifdef FIFO_FWFT_EN
  logic              byp_valid;
  logic [DATA_W-1:0] byp_data;

  // The read register always tracks the next head; a write landing on that head
  // this cycle is not yet visible in storage, so it is forwarded for one cycle.
  assign raddr = rptr_next;
  assign re    = 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      byp_valid <= 1'b0;
      byp_data  <= '0;
    end else begin
      byp_valid <= wr_acc && (wptr == rptr_next);
      byp_data  <= bus.data_in;
    end
  end

  assign bus.data_out = byp_valid ? byp_data : mem_rdata;
`else
  assign raddr        = rptr;
  assign re           = rd_acc;
  assign bus.data_out = mem_rdata;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// tb/tb_param_fifo.sv - scoreboard bench for param_fifo (DATA_W=8, DEPTH=16, AF=14, AE=2)
module tb_param_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AF     = 14;
  localparam int AE     = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  param_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  param_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] sb [$];
  logic [DATA_W-1:0] exp_dout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input logic exp_ov, input logic exp_un);
    int n;
    n = sb.size();
    check("count", 32'(bus.count), 32'(n));
    check("full", 32'(bus.full), 32'(n == DEPTH));
    check("empty", 32'(bus.empty), 32'(n == 0));
    check("almost_full", 32'(bus.almost_full), 32'(n >= AF));
    check("almost_empty", 32'(bus.almost_empty), 32'(n <= AE));
    check("overflow", 32'(bus.overflow), 32'(exp_ov));
    check("underflow", 32'(bus.underflow), 32'(exp_un));
`ifdef FIFO_FWFT_EN
    if (n > 0) check("fwft_head", 32'(bus.data_out), 32'(sb[0]));
`else
    check("data_out", 32'(bus.data_out), 32'(exp_dout));
`endif
  endtask

  // One clock with the given request; the scoreboard is updated with the accept rules
  // and the DUT is sampled 1 time unit after the rising edge.
  task automatic cycle(input logic w, input logic [DATA_W-1:0] d, input logic r);
    logic racc, wacc;
    racc = r && (sb.size() > 0);
    wacc = w && ((sb.size() < DEPTH) || racc);
    reset        = 1'b0;
    bus.en_write = w;
    bus.data_in  = d;
    bus.en_read  = r;
    @(posedge clk);
    if (racc) exp_dout = sb.pop_front();
    if (wacc) sb.push_back(d);
    #1;
    check_status(w && !wacc, r && !racc);
    bus.en_write = 1'b0;
    bus.en_read  = 1'b0;
  endtask

  task automatic do_reset(input logic w);
    reset        = 1'b1;
    bus.en_write = w;
    bus.data_in  = 8'h77;
    bus.en_read  = 1'b0;
    @(posedge clk);
    sb.delete();
    exp_dout = '0;
    #1;
    check_status(1'b0, 1'b0);
    check("reset_data_out", 32'(bus.data_out), 32'h0);
    reset        = 1'b0;
    bus.en_write = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.en_write = 1'b0;
    bus.en_read  = 1'b0;
    bus.data_in  = '0;
    exp_dout     = '0;

    do_reset(1'b0);

    // Fill with 0x01..0x10, then one rejected write
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 8'(i), 1'b0);
    cycle(1'b1, 8'hAA, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);

    // Drain in order, then a rejected read on empty
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    // Read on empty with a same-cycle write: read rejected, write accepted
    cycle(1'b1, 8'h99, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    // Full FIFO streaming across pointer wrap
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'h40 + i), 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1);

    // Reset mid-operation discards contents
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
    do_reset(1'b1);
    cycle(1'b1, 8'h55, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // First-word-fall-through visibility of a single write into an empty FIFO
    cycle(1'b1, 8'h3C, 1'b0);
`ifdef FIFO_FWFT_EN
    check("fwft_3c", 32'(bus.data_out), 32'h3C);
`endif
    cycle(1'b0, 8'h00, 1'b1);

    // Random mixed traffic
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning storage entries; power of two, minimum 4.
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, meaning almost_full asserts when count >= AF_LEVEL.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2, meaning almost_empty asserts when count <= AE_LEVEL.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port en_write, input, 1, write request.
REQ-008 The block SHALL have port data_in, input, DATA_W, write data.
REQ-009 The block SHALL have port en_read, input, 1, read request.
REQ-010 The block SHALL have port data_out, output, DATA_W, read data.
REQ-011 The block SHALL have ports full, empty, almost_full and almost_empty, output, 1 each, registered status flags.
REQ-012 The block SHALL have port count, output, $clog2(DEPTH)+1, current occupancy, 0..DEPTH.
REQ-013 The block SHALL have ports overflow and underflow, output, 1 each, one-cycle pulse per rejected access.

Function
REQ-014 The block SHALL accept a write when en_write=1 and (full=0 or an accepted read occurs in the same cycle).
REQ-015 The block SHALL accept a read when en_read=1 and empty=0; a read when empty SHALL be rejected even if a write is accepted in the same cycle.
REQ-016 Standard mode: the block SHALL present the popped word on data_out in the cycle after an accepted read; data_out SHALL otherwise hold its value.
REQ-017 Pointers SHALL be $clog2(DEPTH) bits wide and wrap modulo DEPTH with no dead entry; all DEPTH entries are usable.
REQ-018 count SHALL update as: +1 write only, -1 read only, unchanged on both or neither.
REQ-019 Flags SHALL reflect the updated count in the same cycle as count: full at count==DEPTH, empty at count==0.
REQ-020 On a rejected write the block SHALL pulse overflow for one cycle and SHALL leave storage, pointers and count unchanged.
REQ-021 On a rejected read the block SHALL pulse underflow for one cycle and SHALL leave data_out, pointers and count unchanged.
REQ-022 Simultaneous read and write when full SHALL both be accepted with count held at DEPTH and no overflow.

Reset
REQ-023 When reset=1 at a clock edge, the block SHALL clear pointers and count, set data_out=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0 and underflow=0.
REQ-024 Reset SHALL take priority over any same-cycle en_write/en_read; storage contents SHALL NOT be cleared.
REQ-025 Reset asserted mid-operation SHALL discard all stored words; the first write after reset SHALL be the first word read.

Configuration
REQ-026 With FIFO_FWFT_EN defined, the block SHALL operate first-word-fall-through: data_out shows the head word whenever empty=0, and an accepted read advances to the next word in the following cycle.
REQ-027 With FIFO_FWFT_EN defined, a word written into an empty FIFO SHALL appear on data_out one cycle after the write with empty deasserting in that same cycle.
REQ-028 Without FIFO_FWFT_EN, the block SHALL behave per REQ-016 and contain no FWFT bypass logic.

Structure
REQ-029 A shared package fifo_pkg SHALL hold the default width/depth constants and the pointer/count width derivation.
REQ-030 Storage SHALL be a sub-module fifo_mem (one write port, one registered read port, DATA_W x DEPTH); control, count and flags SHALL reside in param_fifo.
REQ-031 Elaboration SHALL fail if DEPTH is not a power of two, DEPTH<4, or AE_LEVEL >= AF_LEVEL.

Verification (DATA_W=8, DEPTH=16, AF=14, AE=2)
REQ-032 Reset, then write 0x01..0x10 on 16 consecutive cycles -> count 16, full=1, almost_full=1 from count 14, no overflow.
REQ-033 Full FIFO, write 0xAA -> overflow pulses one cycle, count stays 16; then read 16 -> data_out 0x01..0x10 in order, empty=1.
REQ-034 Empty FIFO, en_read=1 -> underflow pulses one cycle, data_out unchanged, count 0.
REQ-035 Full FIFO, en_read=en_write=1 for 20 cycles with incrementing data -> count stays 16, no flags pulse, order preserved across pointer wrap.
REQ-036 Write 5 words, assert reset for one cycle with en_write=1 -> count 0, empty=1; next write 0x55 then read -> data_out 0x55.
REQ-037 FIFO_FWFT_EN defined, write 0x3C into empty FIFO -> data_out=0x3C and empty=0 the next cycle without en_read.
